// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared MPU widths used by the execution stage and the user event FIFO
package mpu_pkg;

   // Width of one user event word emitted by the MPU core
   localparam int MPU_USER_W = 64;

   // Width of the saturating dropped-event counter
   localparam int MPU_OVF_CNT_W = 16;

endpackage : mpu_pkg

// File: rtl/mpu_user_fifo_ram.sv
// rtl/mpu_user_fifo_ram.sv - DEPTH x MPU_USER_W storage, synchronous write, asynchronous read
module mpu_user_fifo_ram
   import mpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [MPU_USER_W-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [MPU_USER_W-1:0] rdata
);

   // Contents are never reset; the pointer logic decides what is valid
   logic [MPU_USER_W-1:0] mem [DEPTH];

   // Write port: one word per clock when enabled
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port is combinational so the head shows without a clock of delay
   assign rdata = mem[raddr];

endmodule : mpu_user_fifo_ram

// File: rtl/mpu_user_fifo.sv
// rtl/mpu_user_fifo.sv - FWFT buffer for MPU user events with interrupt and overflow accounting
module mpu_user_fifo
   import mpu_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     user_irq,
   input  logic [MPU_USER_W-1:0]    user_data,
   output logic                     out_valid,
   output logic [MPU_USER_W-1:0]    out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     irq_en,
   output logic                     irq,
   output logic                     ovf,
   output logic [MPU_OVF_CNT_W-1:0] ovf_count,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [MPU_OVF_CNT_W-1:0] CNT_MAX = '1;

   logic [AW-1:0]            wr_ptr;
   logic [AW-1:0]            rd_ptr;
   logic [LW-1:0]            level_q;
   logic [LW-1:0]            level_nxt;
   logic                     valid_q;
   logic                     ovf_q;
   logic [MPU_OVF_CNT_W-1:0] cnt_q;

   logic full;
   logic pop;
   logic push_acc;
   logic drop;
   logic ram_we;

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign full     = (level_q == FULL_LEVEL);
   assign pop      = valid_q & out_ready;
   assign push_acc = user_irq & (~full | pop);
   assign drop     = user_irq & full & ~pop;
   assign ram_we   = push_acc & ~sys_rst;

   // Next occupancy from accepted push and pop
   always_comb begin
      level_nxt = level_q;
      case ({push_acc, pop})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

   // Pointers, occupancy and the registered head-valid flag
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level_q <= level_nxt;
         valid_q <= (level_nxt != '0);
      end
   end

   // Sticky overflow and saturating drop counter; a drop beats a concurrent clear
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (clr_ovf) begin
            cnt_q <= MPU_OVF_CNT_W'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + MPU_OVF_CNT_W'(1);
         end
      end else if (clr_ovf) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end
   end

   mpu_user_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (sys_clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (user_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   assign out_valid = valid_q;
   assign level     = level_q;
   assign irq       = irq_en & valid_q;
   assign ovf       = ovf_q;
   assign ovf_count = cnt_q;

endmodule : mpu_user_fifo

// File: tb/tb_mpu_user_fifo.sv
// tb/tb_mpu_user_fifo.sv - self-checking bench for mpu_user_fifo against a queue model
module tb_mpu_user_fifo;

   localparam int DEPTH = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        user_irq = 1'b0;
   logic [63:0] user_data = '0;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready = 1'b0;
   logic [4:0]  level;
   logic        irq_en = 1'b0;
   logic        irq;
   logic        ovf;
   logic [15:0] ovf_count;
   logic        clr_ovf = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   logic [63:0] m_q [$];
   bit          m_ovf = 1'b0;
   int          m_cnt = 0;

   mpu_user_fifo #(.DEPTH(DEPTH)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .user_irq  (user_irq),
      .user_data (user_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level),
      .irq_en    (irq_en),
      .irq       (irq),
      .ovf       (ovf),
      .ovf_count (ovf_count),
      .clr_ovf   (clr_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the FIFO rules, applied once per clock edge with the inputs that edge saw
   task automatic model_edge(input bit rst, input bit push, input logic [63:0] data,
                             input bit ready, input bit clr);
      bit do_pop;
      bit is_full;
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
      end else begin
         do_pop  = (m_q.size() > 0) && ready;
         is_full = (m_q.size() == DEPTH);
         if (do_pop) void'(m_q.pop_front());
         if (push && is_full && !do_pop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
         end else begin
            if (push) m_q.push_back(data);
            if (clr) begin
               m_ovf = 1'b0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit push, input logic [63:0] data,
                       input bit ready, input bit clr);
      sys_rst   = rst;
      user_irq  = push;
      user_data = data;
      out_ready = ready;
      clr_ovf   = clr;
      @(posedge sys_clk);
      model_edge(rst, push, data, ready, clr);
      #1;
      sys_rst   = 1'b0;
      user_irq  = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge sys_clk) begin
      if (cmp_on) begin
         chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
         chk("level", 64'(level), 64'(m_q.size()));
         chk("irq", 64'(irq), 64'(irq_en && (m_q.size() != 0)));
         chk("ovf", 64'(ovf), 64'(m_ovf));
         chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
         if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      cmp_on = 1'b1;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_cnt", 64'(ovf_count), 64'd0);

      // Basic FIFO
      step(0, 1, 64'h1, 0, 0);
      chk("t1_valid_after_first", 64'(out_valid), 64'd1);
      step(0, 1, 64'h2, 0, 0);
      step(0, 1, 64'h3, 0, 0);
      chk("t1_level", 64'(level), 64'd3);
      chk("t1_head", out_data, 64'h1);
      for (int i = 1; i <= 3; i++) begin
         chk("t1_pop_data", out_data, 64'(i));
         step(0, 0, 0, 1, 0);
      end
      chk("t1_empty_valid", 64'(out_valid), 64'd0);
      chk("t1_empty_level", 64'(level), 64'd0);

      // Fill and overflow
      for (int i = 0; i < 18; i++) step(0, 1, 64'h100 + 64'(i), 0, 0);
      chk("t2_level", 64'(level), 64'd16);
      chk("t2_ovf", 64'(ovf), 64'd1);
      chk("t2_cnt", 64'(ovf_count), 64'd2);
      chk("t2_head", out_data, 64'h100);
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain", out_data, 64'h100 + 64'(i));
         step(0, 0, 0, 1, 0);
      end
      chk("t2_drained", 64'(out_valid), 64'd0);
      step(0, 0, 0, 0, 1);
      chk("t2_clr", 64'(ovf), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 16; i++) step(0, 1, 64'h200 + 64'(i), 0, 0);
      for (int k = 0; k < 4; k++) begin
         chk("t3_pp_data", out_data, 64'h200 + 64'(k));
         step(0, 1, 64'h210 + 64'(k), 1, 0);
         chk("t3_pp_level", 64'(level), 64'd16);
      end
      chk("t3_ovf", 64'(ovf), 64'd0);
      for (int i = 4; i < 20; i++) begin
         chk("t3_drain", out_data, 64'h200 + 64'(i));
         step(0, 0, 0, 1, 0);
      end
      chk("t3_drained", 64'(level), 64'd0);

      // Overflow clear race and saturation
      for (int i = 0; i < 21; i++) step(0, 1, 64'h300 + 64'(i), 0, 0);
      chk("t4_cnt5", 64'(ovf_count), 64'd5);
      step(0, 1, 64'hdead, 0, 1);
      chk("t4_race_ovf", 64'(ovf), 64'd1);
      chk("t4_race_cnt", 64'(ovf_count), 64'd1);
      step(0, 0, 0, 0, 1);
      chk("t4_clr_ovf", 64'(ovf), 64'd0);
      chk("t4_clr_cnt", 64'(ovf_count), 64'd0);
      for (int i = 0; i < 70000; i++) step(0, 1, 64'(i), 0, 0);
      chk("t4_sat", 64'(ovf_count), 64'hffff);
      chk("t4_head_kept", out_data, 64'h300);
      step(0, 0, 0, 0, 1);

      // Reset mid-stream and irq gating
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 64'h400 + 64'(i), 0, 0);
      irq_en = 1'b1;
      #1;
      chk("t5_irq_on", 64'(irq), 64'd1);
      chk("t5_level7", 64'(level), 64'd7);
      step(1, 1, 64'hbeef, 0, 0);
      chk("t5_rst_level", 64'(level), 64'd0);
      chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_irq", 64'(irq), 64'd0);
      step(0, 1, 64'h500, 0, 0);
      chk("t5_irq_push", 64'(irq), 64'd1);
      chk("t5_data", out_data, 64'h500);
      irq_en = 1'b0;
      #1;
      chk("t5_irq_gate", 64'(irq), 64'd0);
      step(0, 0, 0, 0, 0);

      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mpu_user_fifo
